// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - start/busy/done handshake bundle for the BCD-to-binary converter
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 4
) ();
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bin_out;
    logic                  err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to binary converter (reverse double dabble), optional BCD_ERR_CHECK_EN
module bcd_to_bin_seq #(
    parameter int DIGITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    bcd_to_bin_seq_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    bcd_r;
    logic [W-1:0]    bin_r;
    logic [W-1:0]    bcd_sh;
    logic [W-1:0]    bin_sh;
    logic [W-1:0]    bin_out_r;
    logic [CW-1:0]   count;
    logic            err_r;
    logic            last_shift;
    logic            bad_digit;

    // One right shift of {bcd_r, bin_r}, then -3 on every digit whose MSB is now set.
    always_comb begin
        bin_sh = {bcd_r[0], bin_r[W-1:1]};
        bcd_sh = {1'b0, bcd_r[W-1:1]};
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sh[4*k+3]) begin
                bcd_sh[4*k +: 4] = bcd_sh[4*k +: 4] - 4'd3;
            end
        end
    end

    assign last_shift = (count == CW'(W - 1));

`ifdef BCD_ERR_CHECK_EN
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.bcd_in[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = bad_digit ? DONE : SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bcd_r     <= '0;
            bin_r     <= '0;
            count     <= '0;
            bin_out_r <= '0;
            err_r     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd_r <= bus.bcd_in;
                        bin_r <= '0;
                        count <= '0;
                        if (bad_digit) begin
                            bin_out_r <= '0;
                            err_r     <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_r <= bcd_sh;
                    bin_r <= bin_sh;
                    count <= count + CW'(1);
                    if (last_shift) begin
                        bin_out_r <= bin_sh;
                        err_r     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (state == SHIFT);
    assign bus.done    = (state == DONE);
    assign bus.bin_out = bin_out_r;
    assign bus.err     = err_r;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_to_bin_seq_if #(.DIGITS(DIGITS)) bus ();

    bcd_to_bin_seq #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] bcd;
        logic [W-1:0] bin;
        logic         err;
        int           n_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts from an IDLE cycle (just after a rising edge); returns one cycle after done.
    task automatic run_conv(input logic [W-1:0] bcd, input logic [W-1:0] exp_bin,
                            input logic exp_err, input int exp_n);
        int n;
        int busy_cnt;
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = ~bcd;
        n = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy) busy_cnt++;
        end
        chk($sformatf("latency %h", bcd), n, exp_n);
        chk($sformatf("bin_out %h", bcd), bus.bin_out, exp_bin);
        chk($sformatf("err %h", bcd), bus.err, exp_err);
        chk($sformatf("busy cycles %h", bcd), busy_cnt, (exp_n == 0) ? 0 : W);
        @(posedge clk);
        #1;
        chk($sformatf("done single %h", bcd), bus.done, 1'b0);
    endtask

    initial begin
        int pulses;
        int d1;
        int d2;
        int d3;
        int dn;
        logic [W-1:0] val;
        logic [W-1:0] vals[3];

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bcd_in = '0;

        vecs.push_back('{16'h9999, 16'h270F, 1'b0, W});
        vecs.push_back('{16'h1234, 16'h04D2, 1'b0, W});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, W});
        vecs.push_back('{16'h0042, 16'h002A, 1'b0, W});
        vecs.push_back('{16'h5678, 16'h162E, 1'b0, W});
        vecs.push_back('{16'h9000, 16'h2328, 1'b0, W});
        vecs.push_back('{16'h0001, 16'h0001, 1'b0, W});
        vecs.push_back('{16'h0099, 16'h0063, 1'b0, W});
`ifdef BCD_ERR_CHECK_EN
        vecs.push_back('{16'h12A4, 16'h0000, 1'b1, 0});
        vecs.push_back('{16'h0007, 16'h0007, 1'b0, W});
        vecs.push_back('{16'h000F, 16'h0000, 1'b1, 0});
        vecs.push_back('{16'h0500, 16'h01F4, 1'b0, W});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset bin_out", bus.bin_out, 16'h0000);
        chk("reset err", bus.err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].n_done);

        // start held high: back-to-back conversions, input changed mid-way through the third
        pulses = 0;
        d1 = 0;
        d2 = 0;
        d3 = 0;
        bus.bcd_in = 16'h0042;
        bus.start  = 1'b1;
        for (int n = 1; n <= 80 && pulses < 3; n++) begin
            @(posedge clk);
            #1;
            if (pulses == 2 && n == d2 + 7) bus.bcd_in = 16'h0099;
            if (bus.done) begin
                vals[pulses] = bus.bin_out;
                pulses++;
                if (pulses == 1) d1 = n;
                if (pulses == 2) d2 = n;
                if (pulses == 3) begin
                    d3 = n;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b pulses", pulses, 3);
        chk("b2b first done", d1, W + 1);
        chk("b2b result 0", vals[0], 16'h002A);
        chk("b2b result 1", vals[1], 16'h002A);
        chk("b2b result 2 (input changed)", vals[2], 16'h002A);
        chk("b2b even spacing", d3 - d2, d2 - d1);
        chk("b2b spacing range", ((d2 - d1) >= W + 1) && ((d2 - d1) <= W + 2), 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // start pulsed during busy must be ignored
        pulses = 0;
        dn = 0;
        val = '0;
        bus.bcd_in = 16'h0500;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h0001;
            end
            if (n == 6) bus.start = 1'b0;
            if (bus.done) begin
                pulses++;
                dn = n;
                val = bus.bin_out;
            end
        end
        chk("ignore pulses", pulses, 1);
        chk("ignore latency", dn, W);
        chk("ignore result", val, 16'h01F4);

        // async reset at cycle 8 of a conversion
        bus.bcd_in = 16'h9999;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre-reset busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort busy", bus.busy, 1'b0);
        chk("abort done", bus.done, 1'b0);
        chk("abort bin_out", bus.bin_out, 16'h0000);
        chk("abort err", bus.err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        chk("abort no done", pulses, 0);
        run_conv(16'h0010, 16'h000A, 1'b0, W);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
